// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-lane data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {ST_INIT, ST_PROG, ST_RUN} state_e;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] adr);
    case (size)
      SZ_BYTE: lane_sel = 4'b0001 << adr;
      SZ_HALF: lane_sel = adr[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] adr);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = adr[0];
      default: misaligned = |adr;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] adr, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (adr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = adr[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_ext = {{24{b[7] & ~uns}}, b};
      SZ_HALF: load_ext = {{16{h[15] & ~uns}}, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-byte write enables and a registered read.
module dmem_bank #(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic [AW-1:0] adr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   dat_i,
  output logic [31:0]   dat_o
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[adr_i][8*i +: 8] <= dat_i[8*i +: 8];
    end
    dat_o <= mem_q[adr_i];
  end

endmodule

// File: rtl/dmem_bytelane.sv
// CPU/UART-programmer data memory: power-on clear, byte/half/word access with
// extension, misalignment flagging and a one-cycle registered load path.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              ram_clk_i,
  input  logic              ram_rst_i,
  input  logic              ram_req_i,
  input  logic              ram_wen_i,
  input  logic [1:0]        ram_size_i,
  input  logic              ram_unsigned_i,
  input  logic [ADDR_W-1:0] ram_adr_i,
  input  logic [31:0]       ram_dat_i,
  output logic [31:0]       ram_dat_o,
  output logic              ram_rvalid_o,
  output logic              ram_misalign_o,
  output logic              ram_ready_o,
  input  logic              upg_active_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-3:0] upg_adr_i,
  input  logic [31:0]       upg_dat_i,
  input  logic              upg_done_i,
  output logic              prog_mode_o
);

  localparam int WA_W = ADDR_W - 2;

  state_e          state_q, state_d;
  logic [WA_W-1:0] cnt_q, cnt_d;
  logic            run, cpu_mis;
  logic [WA_W-1:0] bank_adr;
  logic [3:0]      bank_we;
  logic [31:0]     bank_wdat, bank_rdat;
  logic            rvalid_q, mis_q, uns_q;
  logic [1:0]      size_q, lo_q;
  logic [31:0]     hold_q, ld_res;

  assign run     = (state_q == ST_RUN);
  assign cpu_mis = misaligned(ram_size_i, ram_adr_i[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (CLEAR_ON_RST == 0 || cnt_q == '1) state_d = upg_active_i ? ST_PROG : ST_RUN;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_PROG: if (upg_done_i) state_d = ST_RUN;
      ST_RUN:  if (upg_active_i && !upg_done_i) state_d = ST_PROG;
      default: state_d = ST_INIT;
    endcase
  end

  // Port mux: the clear counter, the programmer or the CPU owns the bank.
  always_comb begin
    bank_adr = ram_adr_i[ADDR_W-1:2];
    bank_we  = 4'h0;
    case (ram_size_i)
      SZ_BYTE: bank_wdat = {4{ram_dat_i[7:0]}};
      SZ_HALF: bank_wdat = {2{ram_dat_i[15:0]}};
      default: bank_wdat = ram_dat_i;
    endcase
    case (state_q)
      ST_INIT: begin
        bank_adr  = cnt_q;
        bank_wdat = '0;
        bank_we   = (CLEAR_ON_RST != 0) ? 4'hF : 4'h0;
      end
      ST_PROG: begin
        bank_adr  = upg_adr_i;
        bank_wdat = upg_dat_i;
        bank_we   = {4{upg_wen_i}};
      end
      default: begin
        if (ram_req_i && ram_wen_i && !cpu_mis) bank_we = lane_sel(ram_size_i, ram_adr_i[1:0]);
      end
    endcase
    if (ram_rst_i) bank_we = 4'h0;
  end

  dmem_bank #(.AW(WA_W)) u_bank (
    .clk_i (ram_clk_i),
    .adr_i (bank_adr),
    .we_i  (bank_we),
    .dat_i (bank_wdat),
    .dat_o (bank_rdat)
  );

  // The bank output moves on every access, so a load result is captured to hold it.
  assign ld_res    = mis_q ? '0 : load_ext(bank_rdat, size_q, lo_q, uns_q);
  assign ram_dat_o = rvalid_q ? ld_res : hold_q;

  always_ff @(posedge ram_clk_i) begin
    if (ram_rst_i) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= SZ_BYTE;
      lo_q     <= 2'b00;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= run & ram_req_i & ~ram_wen_i;
      mis_q    <= run & ram_req_i & cpu_mis;
      if (run && ram_req_i) begin
        size_q <= ram_size_i;
        lo_q   <= ram_adr_i[1:0];
        uns_q  <= ram_unsigned_i;
      end
      if (rvalid_q) hold_q <= ld_res;
    end
  end

  assign ram_rvalid_o   = rvalid_q;
  assign ram_misalign_o = mis_q;
  assign ram_ready_o    = run;
  assign prog_mode_o    = (state_q == ST_PROG);

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
Parametrised successor to the 32-bit data memory. Sits between the CPU datapath (address from ALU, store data from decoder) and an internal inferred RAM. Adds byte/halfword/word loads and stores with sign/zero extension, misalignment detection, a registered read with a valid strobe, and power-on clearing. A mode state machine arbitrates between CPU access and the UART programmer (already synchronised to ram_clk_i).

Parameters:
ADDR_W, 16, CPU byte-address width; DEPTH = 2**(ADDR_W-2) words
CLEAR_ON_RST, 1, 1 = zero every word after reset; 0 = skip the INIT clear

Ports:
ram_clk_i  in  1  single clock; CPU and UPG logic share it
ram_rst_i  in  1  reset, synchronous, active-high
ram_req_i  in  1  CPU access valid this cycle
ram_wen_i  in  1  1 = store, 0 = load (qualified by ram_req_i)
ram_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
ram_unsigned_i  in  1  1 = zero-extend loads, 0 = sign-extend
ram_adr_i  in  ADDR_W  CPU byte address
ram_dat_i  in  32  store data; byte/half stores take the low bits
ram_dat_o  out  32  load result, extended
ram_rvalid_o  out  1  one-cycle pulse: ram_dat_o is new
ram_misalign_o  out  1  one-cycle pulse: previous request was misaligned
ram_ready_o  out  1  1 only in RUN
upg_active_i  in  1  UART programmer owns memory
upg_wen_i  in  1  UPG word write strobe
upg_adr_i  in  ADDR_W-2  UPG word address
upg_dat_i  in  32  UPG write data
upg_done_i  in  1  programming finished
prog_mode_o  out  1  1 in PROG

Behaviour:
- Reset (synchronous, active-high): state=INIT, clear counter=0, ram_dat_o=0, ram_rvalid_o=0, ram_misalign_o=0, ram_ready_o=0, prog_mode_o=0.
- Reset asserted mid-clear, mid-program or mid-access: the current operation is abandoned. The clear restarts from word 0. Memory contents are not otherwise restored.
- States:
  - INIT: writes 0 to word[cnt], cnt++ each cycle. After word DEPTH-1 is written, go to PROG if upg_active_i=1, else RUN. With CLEAR_ON_RST=0, INIT lasts exactly one cycle with no writes.
  - PROG: on upg_wen_i, write upg_dat_i to word[upg_adr_i] (all 4 byte lanes). On upg_done_i, go to RUN. If upg_wen_i and upg_done_i are high in the same cycle, the write commits and the next state is RUN.
  - RUN: serves CPU requests. upg_active_i=1 with upg_done_i=0 moves to PROG next cycle. A CPU request in that same cycle is still served.
- CPU requests outside RUN are ignored: no write, no rvalid, no misalign pulse.
- Alignment rules:
  - half is misaligned when adr[0]=1.
  - word is misaligned when adr[1:0]!=0.
  - byte is always aligned.
- Misaligned request: no write. At N+1, ram_misalign_o=1 and ram_rvalid_o=(~ram_wen_i), with ram_dat_o=0.
- Store, aligned: commits at the edge closing cycle N. Byte-enable selection:
  - byte: lane adr[1:0], data ram_dat_i[7:0] replicated.
  - half: lanes {adr[1],0} and {adr[1],1}, data ram_dat_i[15:0] replicated.
  - word: all lanes.
  - Unselected lanes keep their old value.
- Load, aligned: latency 1. ram_rvalid_o pulses at N+1 with the extended lane data, selected by the registered adr[1:0], size and unsigned bits. ram_dat_o holds its value until the next load result or reset.
- Back-to-back requests are accepted every cycle.
- Store then load to the same word in cycles N and N+1: the load returns the new data.
- Address wrap: none. Every ADDR_W-bit address maps to a valid word.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum {ST_INIT, ST_PROG, ST_RUN}
  - function lane_sel(size, adr[1:0]) returning a 4-bit byte enable
  - function load_ext(word, size, adr[1:0], unsigned) returning 32 bits
- Sub-module dmem_bank: single-port DEPTH x 32 RAM with a 4-bit byte write enable and a synchronous read, written to infer block RAM. The top level contains the FSM, the port mux and the alignment/extension logic.

Test Plan:
- Reset, then idle, with ADDR_W=8, CLEAR_ON_RST=1 -> ram_ready_o rises exactly 64 cycles after reset deasserts; load of word 0x3C returns 0x00000000.
- PROG: upg writes 0x8899AABB to word 5, with upg_done_i in the same cycle -> prog_mode_o falls; RUN load word at 0x14 gives 0x8899AABB, rvalid one cycle later.
- Loads from 0x8899AABB at 0x14:
  - lb 0x17 -> 0xFFFFFF88
  - lbu 0x17 -> 0x00000088
  - lh 0x14 -> 0xFFFFAABB
  - lhu 0x16 -> 0x00008899
- sb 0x5A at 0x15, then lw 0x14 next cycle -> 0x88995ABB (read-after-write, other lanes intact).
- sh at 0x13 and lw at 0x16 -> no memory change, ram_misalign_o pulses for each; lw returns rvalid=1 with 0; later lw 0x14 is unchanged.
- Reset asserted during PROG halfway through 10 writes -> state INIT, counter restarts at 0; CPU req ignored until ram_ready_o=1.
